// File: rtl/pipelined_power_n.sv
// Pipelined unsigned power unit: o_xPower = i_x ** i_power with valid/ready flow control.
// Each multiply is registered as four half-width partial products and recombined in the next stage.
module pipelined_power_n #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_POWER = 3,
  parameter bit          SATURATE  = 1'b0,
  localparam int unsigned PW       = $clog2(MAX_POWER + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [PW-1:0]    i_power,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_xPower,
  output logic             o_overflow
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned LAST = MAX_POWER - 1;

  typedef struct packed {
    logic             vld;
    logic             mul;  // partial-product fields hold acc*x; acc field is stale
    logic             ovf;
    logic [PW-1:0]    p;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] hh;
    logic [WIDTH-1:0] hl;
    logic [WIDTH-1:0] lh;
    logic [WIDTH-1:0] ll;
  } stage_t;

  stage_t             st_q    [MAX_POWER];
  stage_t             st_d    [MAX_POWER];
  logic [2*WIDTH-1:0] prod    [MAX_POWER];
  logic [WIDTH-1:0]   eff_acc [MAX_POWER];
  logic               eff_ovf [MAX_POWER];

  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             adv;

  function automatic logic [WIDTH-1:0] mul_half(input logic [HALF-1:0] a, input logic [HALF-1:0] b);
    return {{HALF{1'b0}}, a} * {{HALF{1'b0}}, b};
  endfunction

  function automatic logic [2*WIDTH-1:0] recombine(input stage_t s);
    logic [WIDTH:0] mid;
    mid = {1'b0, s.hl} + {1'b0, s.lh};
    return {s.hh, {WIDTH{1'b0}}} + ({{(WIDTH-1){1'b0}}, mid} << HALF) + {{WIDTH{1'b0}}, s.ll};
  endfunction

  assign adv     = !valid_q || i_ready;
  assign o_ready = adv;

  // Resolve each stage's true accumulator, folding in any pending partial products.
  always_comb begin
    for (int k = 0; k < int'(MAX_POWER); k++) begin
      prod[k]    = recombine(st_q[k]);
      eff_acc[k] = st_q[k].mul ? prod[k][WIDTH-1:0] : st_q[k].acc;
      eff_ovf[k] = st_q[k].ovf | (st_q[k].mul && (prod[k][2*WIDTH-1:WIDTH] != '0));
    end
  end

  always_comb begin
    for (int k = 0; k < int'(MAX_POWER); k++) begin
      st_d[k] = '0;
    end
    st_d[0].vld = i_valid;
    st_d[0].x   = i_x;
    st_d[0].p   = i_power;
    st_d[0].acc = (i_power == '0) ? WIDTH'(1) : i_x;

    for (int k = 1; k < int'(MAX_POWER); k++) begin
      st_d[k].vld = st_q[k-1].vld;
      st_d[k].x   = st_q[k-1].x;
      st_d[k].p   = st_q[k-1].p;
      st_d[k].ovf = eff_ovf[k-1];
      st_d[k].acc = eff_acc[k-1];
      st_d[k].mul = 32'(st_q[k-1].p) > 32'(k);
      if (st_d[k].mul) begin
        st_d[k].hh = mul_half(eff_acc[k-1][WIDTH-1:HALF], st_q[k-1].x[WIDTH-1:HALF]);
        st_d[k].hl = mul_half(eff_acc[k-1][WIDTH-1:HALF], st_q[k-1].x[HALF-1:0]);
        st_d[k].lh = mul_half(eff_acc[k-1][HALF-1:0], st_q[k-1].x[WIDTH-1:HALF]);
        st_d[k].ll = mul_half(eff_acc[k-1][HALF-1:0], st_q[k-1].x[HALF-1:0]);
      end
    end

    valid_d = st_q[LAST].vld;
    ovf_d   = eff_ovf[LAST];
    res_d   = (SATURATE && eff_ovf[LAST]) ? '1 : eff_acc[LAST];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < int'(MAX_POWER); k++) begin
        st_q[k] <= '0;
      end
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
    end else if (adv) begin
      for (int k = 0; k < int'(MAX_POWER); k++) begin
        st_q[k] <= st_d[k];
      end
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_xPower   = res_q;
  assign o_overflow = ovf_q;

endmodule
